// File: rtl/tt_um_hoene_input_arbiter_pkg.sv
// Shared constants for the LED input arbiter: counter-width defaults and the
// channel-index width derivation used by the top level and its bench.
package tt_um_hoene_input_arbiter_pkg;

  localparam int NUM_IN_DEF = 4;
  localparam int EDGE_W_DEF = 6;
  localparam int IDLE_W_DEF = 10;

  // Width of a channel index: at least one bit even for a single channel.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tt_um_hoene_activity_monitor.sv
// Per-channel activity monitor: counts rising edges up to a saturating
// threshold and forgets them after a long idle stretch.
module tt_um_hoene_activity_monitor
  import tt_um_hoene_input_arbiter_pkg::*;
#(
  parameter int EDGE_W = EDGE_W_DEF,
  parameter int IDLE_W = IDLE_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic qualified
);

  logic              last_in;
  logic [EDGE_W-1:0] edge_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              rise;
  logic              edge_max;
  logic              idle_max;

  // Edge detect and saturation flags.
  always_comb begin
    rise      = in & ~last_in;
    edge_max  = (edge_cnt == '1);
    idle_max  = (idle_cnt == '1);
    qualified = edge_max;
  end

  // Edge/idle counters; a rising edge beats a simultaneous idle timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_in  <= 1'b0;
      edge_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      last_in <= in;
      if (rise) begin
        idle_cnt <= '0;
        if (!edge_max) edge_cnt <= edge_cnt + EDGE_W'(1);
      end else begin
        if (!idle_max) idle_cnt <= idle_cnt + IDLE_W'(1);
        else           edge_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/tt_um_hoene_input_arbiter.sv
// Input arbiter: selects the lowest-index active LED data line (or a forced
// line in test mode) and forwards it registered, switching only while the
// currently selected line is low so no pulse is cut.
module tt_um_hoene_input_arbiter
  import tt_um_hoene_input_arbiter_pkg::*;
#(
  parameter  int NUM_IN = NUM_IN_DEF,
  parameter  int EDGE_W = EDGE_W_DEF,
  parameter  int IDLE_W = IDLE_W_DEF,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] in,
  input  logic              testmode,
  input  logic [SEL_W-1:0]  testsel,
  output logic              out,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_IN-1:0] qualified,
  output logic              sel_change
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_IN - 1);

  logic [SEL_W-1:0] prio_sel;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] sel_next;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_mon
    tt_um_hoene_activity_monitor #(
      .EDGE_W (EDGE_W),
      .IDLE_W (IDLE_W)
    ) u_mon (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in[g]),
      .qualified (qualified[g])
    );
  end

  // Priority encoder over qualified channels (lowest index wins), test-mode
  // override with clamp, and hold while the current line is high.
  // Scanning downward lets the lowest qualified index overwrite last.
  always_comb begin
    prio_sel = LAST_CH;
    for (int unsigned i = NUM_IN; i > 0; i--) begin
      if (qualified[i-1]) prio_sel = SEL_W'(i - 1);
    end
    cand = prio_sel;
    if (testmode) cand = (int'(testsel) >= NUM_IN) ? LAST_CH : testsel;
    sel_next = in[sel] ? sel : cand;
  end

  // Selection, forwarded data and change-pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel        <= LAST_CH;
      out        <= 1'b0;
      sel_change <= 1'b0;
    end else begin
      sel        <= sel_next;
      out        <= in[sel_next];
      sel_change <= (sel_next != sel);
    end
  end

endmodule

// File: tb/tb_tt_um_hoene_input_arbiter.sv
// Directed bench for the LED input arbiter at default parameters.
module tb_tt_um_hoene_input_arbiter;
  import tt_um_hoene_input_arbiter_pkg::*;

  localparam int NUM_IN = NUM_IN_DEF;
  localparam int SEL_W  = sel_width(NUM_IN);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_IN-1:0] in;
  logic              testmode;
  logic [SEL_W-1:0]  testsel;
  logic              out;
  logic [SEL_W-1:0]  sel;
  logic [NUM_IN-1:0] qualified;
  logic              sel_change;

  int errors = 0;
  int checks = 0;

  tt_um_hoene_input_arbiter #(
    .NUM_IN (NUM_IN),
    .EDGE_W (EDGE_W_DEF),
    .IDLE_W (IDLE_W_DEF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .testmode   (testmode),
    .testsel    (testsel),
    .out        (out),
    .sel        (sel),
    .qualified  (qualified),
    .sel_change (sel_change)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in = '0; testmode = 1'b0; testsel = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic pulses(input logic [NUM_IN-1:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      in = mask; tick();
      in = '0;   tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in = '1; testmode = 1'b1; testsel = '0;
    tick(); tick();
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out got=%b exp=0", out); end
    checks++; if (sel !== 2'd3) begin errors++; $display("FAIL reset_sel got=%0d exp=3", sel); end
    checks++; if (sel_change !== 1'b0) begin errors++; $display("FAIL reset_selchg got=%b exp=0", sel_change); end
    checks++; if (qualified !== 4'b0000) begin errors++; $display("FAIL reset_qual got=%b exp=0000", qualified); end
    rst_n = 1'b1; in = '0; testmode = 1'b0;
  endtask

  task automatic test_qualify();
    do_reset();
    pulses(4'b0100, 62);
    checks++; if (qualified !== 4'b0000) begin errors++; $display("FAIL q62_qual got=%b exp=0000", qualified); end
    checks++; if (sel !== 2'd3) begin errors++; $display("FAIL q62_sel got=%0d exp=3", sel); end
    in = 4'b0100; tick();
    checks++; if (qualified !== 4'b0100) begin errors++; $display("FAIL q63_qual got=%b exp=0100", qualified); end
    checks++; if (sel !== 2'd3) begin errors++; $display("FAIL q63_sel_hold got=%0d exp=3", sel); end
    in = '0; tick();
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL q63_sel got=%0d exp=2", sel); end
    checks++; if (sel_change !== 1'b1) begin errors++; $display("FAIL q63_selchg got=%b exp=1", sel_change); end
    tick();
    checks++; if (sel_change !== 1'b0) begin errors++; $display("FAIL q63_selchg_single got=%b exp=0", sel_change); end
  endtask

  task automatic test_timeout();
    do_reset();
    pulses(4'b0110, 63);
    checks++; if (sel !== 2'd1) begin errors++; $display("FAIL to_sel1 got=%0d exp=1", sel); end
    // last edge on in[1] was two edges ago; 1022 more leave idle at 1023
    for (int k = 0; k < 1022; k++) begin
      in[2] = ~in[2]; tick();
    end
    checks++; if (qualified !== 4'b0110) begin errors++; $display("FAIL to_before got=%b exp=0110", qualified); end
    in[2] = ~in[2]; tick();
    checks++; if (qualified !== 4'b0100) begin errors++; $display("FAIL to_drop got=%b exp=0100", qualified); end
    checks++; if (sel !== 2'd1) begin errors++; $display("FAIL to_sel_hold got=%0d exp=1", sel); end
    in[2] = ~in[2]; tick();
    checks++; if (sel !== 2'd2) begin errors++; $display("FAIL to_sel2 got=%0d exp=2", sel); end
    checks++; if (sel_change !== 1'b1) begin errors++; $display("FAIL to_selchg got=%b exp=1", sel_change); end
  endtask

  task automatic test_no_truncate();
    do_reset();
    pulses(4'b0100, 63);
    tick();
    in = 4'b0100; testmode = 1'b1; testsel = 2'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (sel !== 2'd2) begin errors++; $display("FAIL hold_sel[%0d] got=%0d exp=2", k, sel); end
      checks++; if (out !== 1'b1) begin errors++; $display("FAIL hold_out[%0d] got=%b exp=1", k, out); end
    end
    in = '0; tick();
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL hold_switch got=%0d exp=0", sel); end
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL hold_out_low got=%b exp=0", out); end
    checks++; if (sel_change !== 1'b1) begin errors++; $display("FAIL hold_selchg got=%b exp=1", sel_change); end
    testmode = 1'b0;
  endtask

  task automatic test_testmode();
    logic [4:0] pat;
    pat = 5'b01101;
    do_reset();
    testmode = 1'b1; testsel = 2'd0; tick();
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL tm_sel got=%0d exp=0", sel); end
    for (int k = 0; k < 5; k++) begin
      in = {3'b000, pat[k]}; tick();
      checks++; if (out !== pat[k]) begin errors++; $display("FAIL tm_out[%0d] got=%b exp=%b", k, out, pat[k]); end
    end
    testmode = 1'b0; in = 4'b0001; tick();
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL tm_exit_hold got=%0d exp=0", sel); end
    in = '0; tick();
    checks++; if (sel !== 2'd3) begin errors++; $display("FAIL tm_exit got=%0d exp=3", sel); end
  endtask

  task automatic test_edge_beats_timeout();
    do_reset();
    pulses(4'b0001, 63);
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL race_sel got=%0d exp=0", sel); end
    for (int k = 0; k < 1022; k++) tick();
    in = 4'b0001; tick();
    checks++; if (qualified !== 4'b0001) begin errors++; $display("FAIL race_qual got=%b exp=0001", qualified); end
    checks++; if (out !== 1'b1) begin errors++; $display("FAIL race_out got=%b exp=1", out); end
    in = '0; tick(); tick();
    checks++; if (qualified !== 4'b0001) begin errors++; $display("FAIL race_qual_after got=%b exp=0001", qualified); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    pulses(4'b0010, 63);
    in = 4'b0010; tick();
    checks++; if (sel !== 2'd1 || out !== 1'b1) begin errors++; $display("FAIL mid_pre sel=%0d out=%b exp sel=1 out=1", sel, out); end
    rst_n = 1'b0; testmode = 1'b1; tick();
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL mid_out got=%b exp=0", out); end
    checks++; if (sel !== 2'd3) begin errors++; $display("FAIL mid_sel got=%0d exp=3", sel); end
    checks++; if (qualified !== 4'b0000) begin errors++; $display("FAIL mid_qual got=%b exp=0000", qualified); end
    checks++; if (sel_change !== 1'b0) begin errors++; $display("FAIL mid_selchg got=%b exp=0", sel_change); end
    rst_n = 1'b1; testmode = 1'b0; in = '0;
  endtask

  initial begin
    rst_n = 1'b0; in = '0; testmode = 1'b0; testsel = '0;
    test_reset();
    test_qualify();
    test_timeout();
    test_no_truncate();
    test_testmode();
    test_edge_beats_timeout();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
